gpio_pin_sampler: RTL and testbench
===================================

Name: gpio_pin_sampler

Overview:
- Input stage directly upstream of the GPIO port register.
- Synchronises raw external pin drive (high / low / float) into the clock domain and samples it once per instruction-cycle strobe.
- Produces the resolved GPIO read value: floating pins read back the output latch; driven pins read their level.
- Emits per-pin posedge/negedge pulses and a sticky wake-on-change flag for the sleep/wake logic.

Parameters:
- IO_PINS, 6: number of GPIO pins.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; minimum 2.
- DEBOUNCE_CNT, 4: consecutive stable samples needed to accept a new state. Used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pin_high  in  IO_PINS  raw: pin externally driven high
- pin_low  in  IO_PINS  raw: pin externally driven low
- gpio_latch  in  IO_PINS  current GPIO output latch value
- sample_en  in  1  one-cycle sampling strobe, once per instruction cycle
- wake_en  in  1  enables wake-on-change capture
- wake_clr  in  1  clears the sticky wake flag
- gpio_rd  out  IO_PINS  resolved read value
- state_high  out  IO_PINS  accepted state is HIGH
- state_low  out  IO_PINS  accepted state is LOW
- state_float  out  IO_PINS  accepted state is FLOAT
- pos_edge  out  IO_PINS  one-cycle pulse: pin changed to HIGH
- neg_edge  out  IO_PINS  one-cycle pulse: pin changed to anything other than HIGH
- wake  out  1  sticky: change seen while wake_en
- conflict  out  1  sticky: a pin had high and low asserted together

Behaviour:
- Raw decode after the synchroniser:
  - high=1, low=0 → HIGH
  - high=0, low=1 → LOW
  - 0/0 → FLOAT
  - 1/1 → FLOAT, and sets conflict.
- Accepted per-pin state register updates only in a cycle where sample_en=1.
- Latency: a raw change reaches the accepted state on the first sample_en occurring at least SYNC_STAGES cycles later.
- Edge pulses: in the update cycle, for each pin whose accepted state changes:
  - new state HIGH → pos_edge=1
  - any other change (LOW↔FLOAT, HIGH→LOW, HIGH→FLOAT) → neg_edge=1
  - Outputs are registered, so pulses appear one cycle after the sample_en cycle and last exactly one cycle.
  - At most one of pos_edge/neg_edge is set per pin. With no change, or no sample_en, both are 0.
- Prime flag: cleared by reset; set by the first sample_en. That first sample loads state with no edge pulses and no wake.
- gpio_rd = ((state_float & gpio_latch) | state_high) & GPIO_MASK. Combinational from the registered state and live gpio_latch.
- wake:
  - Set in the cycle after any pos_edge/neg_edge pulse while wake_en=1.
  - Cleared by wake_clr.
  - Set and clear in the same cycle: set wins.
  - wake_en=0 blocks new sets but does not clear the flag.
- conflict: sticky; cleared only by reset.
- Reset (asynchronous, any time, including mid-debounce):
  - Accepted states → FLOAT, so state_float=all 1s and gpio_rd=gpio_latch&mask.
  - pos_edge, neg_edge, wake, conflict, state_high, state_low → 0.
  - Synchronisers, prime flag and counters cleared.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined: per pin, a candidate state differing from the accepted state must be seen on DEBOUNCE_CNT consecutive sample_en strobes before it is accepted.
  - Counter resets if the candidate changes, or if the candidate equals the accepted state.
  - Counter saturates; it never wraps.
  - The prime sample bypasses debounce.
- Undefined: the candidate is accepted on the first sample_en. No counter logic is present.

Decomposition:
- Shared package gpio_pkg:
  - pin_state_t: FLOAT=2'b00, LOW=2'b01, HIGH=2'b10
  - transition_t: NIL, POSEDGE, NEGEDGE
  - IO_PINS = 6
  - GPIO_MASK = 6'h3F
- One sub-module, gpio_pin_channel: per-pin synchroniser, decode, optional debounce and edge detect. Instantiated IO_PINS times in a generate loop.
- Top level holds the prime flag, wake/conflict flags and gpio_rd resolution.

Test Plan:
- Reset, all pins float, gpio_latch=6'h2A → gpio_rd=6'h2A, state_float=6'h3F, no edges, wake=0.
- Prime sample with pin_high=6'h01 → state_high=6'h01, no pos_edge, wake=0.
- Next sample with pin_high=6'h03, wake_en=1 → pos_edge=6'h02 for one cycle; wake=1 on the following cycle; gpio_rd=(latch&6'h3C)|6'h03.
- Pin0 HIGH→FLOAT on a sample while wake_clr=1 in the same cycle wake sets → neg_edge=6'h01; wake remains 1 (set wins); a later lone wake_clr clears it.
- pin_high=pin_low=6'h10 → pin4 state FLOAT, conflict=1 until rst.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CNT=4: pin2 goes LOW for 3 samples then reverts → no edge. Held LOW for 4 samples → neg_edge after the 4th sample. rst asserted after 2 samples → counter cleared and state FLOAT.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO input sampler slice.
package gpio_pkg;

    localparam int IO_PINS = 6;
    localparam logic [IO_PINS-1:0] GPIO_MASK = 6'h3F;

    typedef enum logic [1:0] {
        FLOAT = 2'b00,
        LOW   = 2'b01,
        HIGH  = 2'b10
    } pin_state_t;

    typedef enum logic [1:0] {
        NIL,
        POSEDGE,
        NEGEDGE
    } transition_t;

endpackage

// File: rtl/gpio_pin_channel.sv
// One GPIO pin: synchroniser, high/low/float decode, accepted-state register and edge pulses.
// Build option GPIO_DEBOUNCE_EN adds a DEBOUNCE_CNT-strobe stability filter before acceptance.
module gpio_pin_channel
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CNT = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pinHigh,
    input  logic       pinLow,
    input  logic       sampleEn,
    input  logic       primed,
    output pin_state_t state,
    output logic       posEdge,
    output logic       negEdge,
    output logic       conflict
);

    logic [SYNC_STAGES-1:0] syncHigh;
    logic [SYNC_STAGES-1:0] syncLow;
    pin_state_t             candidate;
    transition_t            transition;
    logic                   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncHigh <= '0;
            syncLow  <= '0;
        end else begin
            syncHigh <= {syncHigh[SYNC_STAGES-2:0], pinHigh};
            syncLow  <= {syncLow[SYNC_STAGES-2:0], pinLow};
        end
    end

    // Both drivers asserted resolves to FLOAT; the contention is reported separately.
    always_comb begin
        candidate = FLOAT;
        case ({syncHigh[SYNC_STAGES-1], syncLow[SYNC_STAGES-1]})
            2'b10:   candidate = HIGH;
            2'b01:   candidate = LOW;
            default: candidate = FLOAT;
        endcase
    end

    assign conflict = syncHigh[SYNC_STAGES-1] & syncLow[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int              CntW   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);

    logic [CntW-1:0] stableCnt;
    logic [CntW-1:0] cntNext;
    pin_state_t      lastCand;

    // Counts consecutive strobes of one candidate that differs from the accepted state.
    always_comb begin
        cntNext = '0;
        if (candidate != state) begin
            if (candidate != lastCand) begin
                cntNext = CntW'(1);
            end else if (stableCnt == CntMax) begin
                cntNext = CntMax;
            end else begin
                cntNext = stableCnt + CntW'(1);
            end
        end
    end

    assign accept = (cntNext >= CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stableCnt <= '0;
            lastCand  <= FLOAT;
        end else if (sampleEn) begin
            lastCand  <= candidate;
            stableCnt <= (!primed || accept) ? '0 : cntNext;
        end
    end
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        transition = NIL;
        if (sampleEn && primed && accept && (candidate != state)) begin
            transition = (candidate == HIGH) ? POSEDGE : NEGEDGE;
        end
    end

    // The priming strobe loads the state directly and never raises an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FLOAT;
            posEdge <= 1'b0;
            negEdge <= 1'b0;
        end else begin
            posEdge <= (transition == POSEDGE);
            negEdge <= (transition == NEGEDGE);
            if (sampleEn && (!primed || accept)) begin
                state <= candidate;
            end
        end
    end

endmodule

// File: rtl/gpio_pin_sampler.sv
// GPIO input sampler: per-pin channels plus prime flag, sticky wake/conflict flags and read resolution.
// Build option GPIO_DEBOUNCE_EN enables per-pin debounce of DEBOUNCE_CNT consecutive strobes.
module gpio_pin_sampler #(
    parameter int IO_PINS      = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IO_PINS-1:0] pin_high,
    input  logic [IO_PINS-1:0] pin_low,
    input  logic [IO_PINS-1:0] gpio_latch,
    input  logic               sample_en,
    input  logic               wake_en,
    input  logic               wake_clr,
    output logic [IO_PINS-1:0] gpio_rd,
    output logic [IO_PINS-1:0] state_high,
    output logic [IO_PINS-1:0] state_low,
    output logic [IO_PINS-1:0] state_float,
    output logic [IO_PINS-1:0] pos_edge,
    output logic [IO_PINS-1:0] neg_edge,
    output logic               wake,
    output logic               conflict
);
    import gpio_pkg::*;

    localparam logic [IO_PINS-1:0] RdMask = IO_PINS'(GPIO_MASK);

    if (SYNC_STAGES < 2 || DEBOUNCE_CNT < 1) begin : gBadParams
        $error("gpio_pin_sampler: SYNC_STAGES must be >= 2 and DEBOUNCE_CNT >= 1");
    end

    logic               primed;
    logic [IO_PINS-1:0] pinConflict;
    pin_state_t         pinState [IO_PINS];

    for (genvar i = 0; i < IO_PINS; i++) begin : gPin
        gpio_pin_channel #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            , .DEBOUNCE_CNT(DEBOUNCE_CNT)
`endif
        ) uChannel (
            .clk      (clk),
            .rst      (rst),
            .pinHigh  (pin_high[i]),
            .pinLow   (pin_low[i]),
            .sampleEn (sample_en),
            .primed   (primed),
            .state    (pinState[i]),
            .posEdge  (pos_edge[i]),
            .negEdge  (neg_edge[i]),
            .conflict (pinConflict[i])
        );

        assign state_high[i]  = (pinState[i] == HIGH);
        assign state_low[i]   = (pinState[i] == LOW);
        assign state_float[i] = (pinState[i] == FLOAT);
    end

    // Floating pins read back whatever the port is driving out.
    assign gpio_rd = ((state_float & gpio_latch) | state_high) & RdMask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed   <= 1'b0;
            wake     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            primed   <= primed | sample_en;
            conflict <= conflict | (|pinConflict);
            if (wake_en && (|(pos_edge | neg_edge))) begin
                wake <= 1'b1;
            end else if (wake_clr) begin
                wake <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_pin_sampler.sv
// Self-checking bench for gpio_pin_sampler against a per-pin behavioural model.
// Debounce expectations follow GPIO_DEBOUNCE_EN when it is defined for the build.
module tb_gpio_pin_sampler;

    localparam int N   = 6;
    localparam int S   = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] pinHigh = '0;
    logic [N-1:0] pinLow = '0;
    logic [N-1:0] gpioLatch = '0;
    logic         sampleEn = 1'b0;
    logic         wakeEn = 1'b0;
    logic         wakeClr = 1'b0;
    logic [N-1:0] gpioRd, stateHigh, stateLow, stateFloat, posEdge, negEdge;
    logic         wake, conflict;

    int checks = 0;
    int errors = 0;

    // Model: raw history delayed by the synchroniser depth, accepted states, pulses and flags.
    logic [N-1:0] histHigh[$];
    logic [N-1:0] histLow[$];
    logic [N-1:0] mHigh, mLow, mPos, mNeg;
    logic         mWake, mConflict, mPrimed;
    int           lastCand[N];
    int           runLen[N];

    gpio_pin_sampler #(.IO_PINS(N), .SYNC_STAGES(S), .DEBOUNCE_CNT(DEB)) dut (
        .clk(clk), .rst(rst), .pin_high(pinHigh), .pin_low(pinLow),
        .gpio_latch(gpioLatch), .sample_en(sampleEn), .wake_en(wakeEn),
        .wake_clr(wakeClr), .gpio_rd(gpioRd), .state_high(stateHigh),
        .state_low(stateLow), .state_float(stateFloat), .pos_edge(posEdge),
        .neg_edge(negEdge), .wake(wake), .conflict(conflict)
    );

    always #5 clk = ~clk;

    function automatic int decode(logic h, logic l);
        if (h && !l) return 2;
        if (!h && l) return 1;
        return 0;
    endfunction

    function automatic logic [N-1:0] expRd();
        logic [N-1:0] r = '0;
        for (int p = 0; p < N; p++) begin
            if (mHigh[p]) r[p] = 1'b1;
            else if (!mLow[p]) r[p] = gpioLatch[p];
        end
        return r;
    endfunction

    task automatic modelReset();
        histHigh = {};
        histLow = {};
        for (int i = 0; i < S; i++) begin
            histHigh.push_back('0);
            histLow.push_back('0);
        end
        mHigh = '0; mLow = '0; mPos = '0; mNeg = '0;
        mWake = 1'b0; mConflict = 1'b0; mPrimed = 1'b0;
        for (int p = 0; p < N; p++) begin
            lastCand[p] = 0;
            runLen[p] = 0;
        end
    endtask

    task automatic modelEdge();
        logic [N-1:0] cH, cL, nPos, nNeg;
        int cand, acc, newSt;
        histHigh.push_back(pinHigh);
        histLow.push_back(pinLow);
        cH = histHigh.pop_front();
        cL = histLow.pop_front();
        if ((cH & cL) != '0) mConflict = 1'b1;
        if (wakeEn && ((mPos | mNeg) != '0)) mWake = 1'b1;
        else if (wakeClr) mWake = 1'b0;
        nPos = '0;
        nNeg = '0;
        if (sampleEn) begin
            for (int p = 0; p < N; p++) begin
                cand = decode(cH[p], cL[p]);
                acc = mHigh[p] ? 2 : (mLow[p] ? 1 : 0);
                if (!mPrimed) begin
                    newSt = cand;
                    runLen[p] = 0;
                end else begin
`ifdef GPIO_DEBOUNCE_EN
                    newSt = acc;
                    if (cand == acc) runLen[p] = 0;
                    else begin
                        runLen[p] = (cand == lastCand[p]) ? runLen[p] + 1 : 1;
                        if (runLen[p] >= DEB) begin
                            newSt = cand;
                            runLen[p] = 0;
                        end
                    end
`else
                    newSt = cand;
`endif
                    if (newSt != acc) begin
                        if (newSt == 2) nPos[p] = 1'b1;
                        else nNeg[p] = 1'b1;
                    end
                end
                lastCand[p] = cand;
                mHigh[p] = (newSt == 2);
                mLow[p] = (newSt == 1);
            end
            mPrimed = 1'b1;
        end
        mPos = nPos;
        mNeg = nNeg;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) modelEdge();
        #1;
    endtask

    task automatic sampleOnce();
        sampleEn = 1'b1;
        tick();
        sampleEn = 1'b0;
    endtask

    task automatic test_reset();
        gpioLatch = 6'h2A;
        #2 rst = 1'b1;
        modelReset();
        #1;
        checks++; if (gpioRd !== 6'h2A) begin errors++; $display("FAIL reset_rd: got %h want %h", gpioRd, 6'h2A); end
        checks++; if (stateFloat !== 6'h3F) begin errors++; $display("FAIL reset_float: got %h want %h", stateFloat, 6'h3F); end
        checks++; if ((stateHigh | stateLow) !== 6'h00) begin errors++; $display("FAIL reset_hl: got %h/%h want 00/00", stateHigh, stateLow); end
        checks++; if ((posEdge | negEdge) !== 6'h00) begin errors++; $display("FAIL reset_edges: got %h/%h want 00/00", posEdge, negEdge); end
        checks++; if ({wake, conflict} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", wake, conflict); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_prime();
        pinHigh = 6'h01;
        wakeEn = 1'b1;
        tick(); tick(); tick();
        sampleOnce();
        checks++; if (stateHigh !== 6'h01) begin errors++; $display("FAIL prime_high: got %h want %h", stateHigh, 6'h01); end
        checks++; if (posEdge !== 6'h00) begin errors++; $display("FAIL prime_pos: got %h want %h", posEdge, 6'h00); end
        tick();
        checks++; if (wake !== 1'b0) begin errors++; $display("FAIL prime_wake: got %b want 0", wake); end
    endtask

    task automatic test_posedge();
        pinHigh = 6'h03;
        tick(); tick();
        sampleOnce();
        checks++; if (posEdge !== 6'h02) begin errors++; $display("FAIL rise_pos: got %h want %h", posEdge, 6'h02); end
        checks++; if (negEdge !== 6'h00) begin errors++; $display("FAIL rise_neg: got %h want %h", negEdge, 6'h00); end
        tick();
        checks++; if (posEdge !== 6'h00) begin errors++; $display("FAIL rise_pulse_len: got %h want %h", posEdge, 6'h00); end
        checks++; if (wake !== 1'b1) begin errors++; $display("FAIL rise_wake: got %b want 1", wake); end
        checks++; if (gpioRd !== ((gpioLatch & 6'h3C) | 6'h03)) begin errors++; $display("FAIL rise_rd: got %h want %h", gpioRd, (gpioLatch & 6'h3C) | 6'h03); end
    endtask

    task automatic test_wake_clr();
        pinHigh = 6'h02;
        tick(); tick();
        sampleOnce();
        checks++; if (negEdge !== 6'h01) begin errors++; $display("FAIL fall_neg: got %h want %h", negEdge, 6'h01); end
        wakeClr = 1'b1;
        tick();
        checks++; if (wake !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", wake); end
        tick();
        wakeClr = 1'b0;
        checks++; if (wake !== 1'b0) begin errors++; $display("FAIL wake_clr: got %b want 0", wake); end
    endtask

    task automatic test_conflict();
        pinHigh = 6'h12;
        pinLow = 6'h10;
        tick(); tick();
        sampleOnce();
        checks++; if (stateFloat[4] !== 1'b1) begin errors++; $display("FAIL conflict_float: got %b want 1", stateFloat[4]); end
        checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b want 1", conflict); end
        pinHigh = 6'h02;
        pinLow = 6'h00;
        for (int k = 0; k < 4; k++) tick();
        sampleOnce();
        checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b want 1", conflict); end
        checks++; if (stateHigh !== mHigh) begin errors++; $display("FAIL conflict_high: got %h want %h", stateHigh, mHigh); end
    endtask

    task automatic test_debounce();
        pinLow = 6'h04;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            sampleOnce();
            checks++; if (negEdge !== mNeg) begin errors++; $display("FAIL glitch_neg: got %h want %h", negEdge, mNeg); end
`ifdef GPIO_DEBOUNCE_EN
            checks++; if (negEdge !== 6'h00) begin errors++; $display("FAIL glitch_filtered: got %h want %h", negEdge, 6'h00); end
`endif
            tick();
        end
        pinLow = 6'h00;
        tick(); tick();
        sampleOnce();
        checks++; if (stateLow !== mLow) begin errors++; $display("FAIL revert_low: got %h want %h", stateLow, mLow); end
        pinLow = 6'h04;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            sampleOnce();
            checks++; if (negEdge !== mNeg) begin errors++; $display("FAIL hold_neg: got %h want %h", negEdge, mNeg); end
`ifdef GPIO_DEBOUNCE_EN
            checks++; if (negEdge !== ((k == 3) ? 6'h04 : 6'h00)) begin errors++; $display("FAIL hold_accept: got %h want %h", negEdge, (k == 3) ? 6'h04 : 6'h00); end
`endif
            tick();
        end
        pinHigh = 6'h06;
        pinLow = 6'h00;
        tick(); tick();
        sampleOnce();
        tick();
        sampleOnce();
        rst = 1'b1;
        modelReset();
        #1;
        checks++; if (stateFloat !== 6'h3F) begin errors++; $display("FAIL midrst_float: got %h want %h", stateFloat, 6'h3F); end
        checks++; if (gpioRd !== (gpioLatch & 6'h3F)) begin errors++; $display("FAIL midrst_rd: got %h want %h", gpioRd, gpioLatch & 6'h3F); end
        checks++; if ({posEdge, negEdge} !== 12'h000) begin errors++; $display("FAIL midrst_edges: got %h/%h want 00/00", posEdge, negEdge); end
        tick();
        rst = 1'b0;
        pinHigh = 6'h02;
        pinLow = 6'h04;
        tick(); tick();
        sampleOnce();
        checks++; if (stateLow !== 6'h04) begin errors++; $display("FAIL reprime_low: got %h want %h", stateLow, 6'h04); end
        pinHigh = 6'h06;
        pinLow = 6'h00;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            sampleOnce();
            checks++; if (posEdge !== mPos) begin errors++; $display("FAIL cnt_cleared: got %h want %h", posEdge, mPos); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                pinHigh = 6'($urandom);
                pinLow = 6'($urandom) & 6'($urandom);
            end
            gpioLatch = 6'($urandom);
            sampleEn = ($urandom_range(0, 2) == 0);
            wakeEn = ($urandom_range(0, 1) == 0);
            wakeClr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                modelReset();
            end
            tick();
            rst = 1'b0;
            checks++; if (stateHigh !== mHigh) begin errors++; $display("FAIL rnd_high c=%0d: got %h want %h", c, stateHigh, mHigh); end
            checks++; if (stateLow !== mLow) begin errors++; $display("FAIL rnd_low c=%0d: got %h want %h", c, stateLow, mLow); end
            checks++; if (stateFloat !== ~(mHigh | mLow)) begin errors++; $display("FAIL rnd_float c=%0d: got %h want %h", c, stateFloat, ~(mHigh | mLow)); end
            checks++; if (posEdge !== mPos) begin errors++; $display("FAIL rnd_pos c=%0d: got %h want %h", c, posEdge, mPos); end
            checks++; if (negEdge !== mNeg) begin errors++; $display("FAIL rnd_neg c=%0d: got %h want %h", c, negEdge, mNeg); end
            checks++; if (wake !== mWake) begin errors++; $display("FAIL rnd_wake c=%0d: got %b want %b", c, wake, mWake); end
            checks++; if (conflict !== mConflict) begin errors++; $display("FAIL rnd_conflict c=%0d: got %b want %b", c, conflict, mConflict); end
            checks++; if (gpioRd !== expRd()) begin errors++; $display("FAIL rnd_rd c=%0d: got %h want %h", c, gpioRd, expRd()); end
        end
        sampleEn = 1'b0;
        wakeClr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_posedge();
        test_wake_clr();
        test_conflict();
        test_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
